huffman_decoder: RTL and testbench
==================================

Name: huffman_decoder

Overview:
- Serial Huffman decoder; the receive-side counterpart of the 6-symbol gray-level Huffman encoder.
- Loads the encoder's code table (HCk codes, Mk masks), then consumes a bitstream MSB-first (root decision first) and emits decoded symbol indices 1..6.
- Sits downstream of the bit-serial channel, feeding a symbol consumer through a valid/ready handshake.

Parameters:
- MAXLEN, 7, longest legal code length in bits; the accumulator is 8 bits wide.
- CNTW, 7, width of the decoded-symbol counter.

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  synchronous, active-high.
- tbl_load  input  1  one-cycle pulse; captures hc_table and m_table.
- hc_table  input  48  HCk = hc_table[8k-1:8k-8], k=1..6; code right-aligned.
- m_table  input  48  Mk = m_table[8k-1:8k-8]; right-aligned ones, count = code length.
- bit_valid  input  1  bit_in is valid.
- bit_in  input  1  next code bit.
- bit_ready  output  1  decoder accepts a bit this cycle.
- sym_valid  output  1  sym holds a decoded symbol.
- sym_ready  input  1  consumer accepts sym.
- sym  output  3  decoded symbol index, 1..6.
- err  output  1  sticky error flag.
- sym_cnt  output  CNTW  symbols handed off; saturates at 2^CNTW-1.

Behaviour:
- Reset values: bit_ready=0, sym_valid=0, sym=0, err=0, sym_cnt=0, acc=0, len=0. Table registers cleared; state=EMPTY.
- States:
  - EMPTY: no table loaded. bit_ready=0. tbl_load -> RUN, or ERR if the table is invalid.
  - RUN: bit_ready = !sym_valid.
  - HOLD: sym_valid=1, bit_ready=0.
  - ERR: err=1, bit_ready=0, sym_valid=0.
- Table validation at load: every Mk must equal 2^L-1 with 1<=L<=MAXLEN, and HCk & ~Mk must be 0. Any violation -> ERR. The prefix-free property is not checked.
- Bit accept occurs when bit_valid && bit_ready at an edge:
  - acc <= {acc[6:0], bit_in}; len <= len+1.
  - Match test is combinational on the updated acc/len. Symbol k matches when popcount(Mk)==len and (acc & Mk)==HCk.
  - On a match, at the same edge: sym<=k, sym_valid<=1, acc<=0, len<=0, state -> HOLD.
  - Latency: sym_valid is high in the cycle immediately after the edge that accepted the final code bit.
  - Multiple matches (non-prefix-free table): the lowest k wins.
  - No match with new len==MAXLEN: state -> ERR, sym_valid stays 0.
- HOLD: on sym_valid && sym_ready, sym_valid<=0, sym_cnt increments (saturating), state -> RUN. The next bit can be accepted in the following cycle, so there is one bubble per symbol.
- tbl_load in any state, including mid-code, HOLD, or ERR:
  - Clears acc, len, sym_valid, err, and sym_cnt, then re-validates the new table.
  - The pending symbol is dropped without a handshake.
- ERR exits only via reset or tbl_load.
- reset takes priority over tbl_load and over all handshakes in the same cycle.
- Bits presented while bit_ready=0 are ignored; the upstream holds them.

Test Plan:
- Reset then idle -> bit_ready=0, sym_valid=0, err=0, sym_cnt=0 while EMPTY.
- Load the reference table, sym_ready=1:
  - HC1..6 = 01,00,03,04,0B,0A; M1..6 = 01,03,07,0F,1F,1F (all hex).
  - Stream 1,0,0,0,1,1,0,1,0,0,0,1,0,1,1,0,1,0,1,0.
  - Expect sym 1,2,3,4,5,6 in order, each valid one cycle after its last bit; sym_cnt=6; err=0.
- Backpressure: same table, sym_ready=0 for 5 cycles after the first sym=1 -> sym_valid and sym=1 held, bit_ready=0 throughout. After sym_ready rises, the stream resumes with no bit lost.
- Invalid table: M3=8'h05 on load -> err=1 next cycle, bit_ready=0.
- Overlong code: all Mk=1F, HCk = 01..06 (5-bit codes). Stream seven 1s -> err=1 after the 7th accepted bit, no sym_valid.
- Reload mid-code: accept bits 0,1 then pulse tbl_load with the reference table -> acc/len cleared. The following stream 1 yields sym=1, not a 3-bit code; sym_cnt restarts from 0.

Source files
------------

// File: rtl/huffman_decoder_if.sv
// Bus bundle between the bit-serial channel / symbol consumer and the Huffman decoder.
interface huffman_decoder_if #(
    parameter int unsigned CNTW = 7
);
    localparam int unsigned TBLW = 48;

    logic            tbl_load;
    logic [TBLW-1:0] hc_table;
    logic [TBLW-1:0] m_table;
    logic            bit_valid;
    logic            bit_in;
    logic            bit_ready;
    logic            sym_valid;
    logic            sym_ready;
    logic [2:0]      sym;
    logic            err;
    logic [CNTW-1:0] sym_cnt;

    // Upstream / consumer side
    modport master (
        output tbl_load, hc_table, m_table, bit_valid, bit_in, sym_ready,
        input  bit_ready, sym_valid, sym, err, sym_cnt
    );

    // Decoder side
    modport slave (
        input  tbl_load, hc_table, m_table, bit_valid, bit_in, sym_ready,
        output bit_ready, sym_valid, sym, err, sym_cnt
    );
endinterface

// File: rtl/huffman_decoder.sv
// Serial 6-symbol Huffman decoder: loads a code/mask table, shifts bits in MSB-first
// and hands decoded symbol indices 1..6 to a consumer over valid/ready.
module huffman_decoder #(
    parameter int unsigned MAXLEN = 7,
    parameter int unsigned CNTW   = 7
) (
    input  logic             clk,
    input  logic             reset,
    huffman_decoder_if.slave bus
);
    localparam int unsigned ACCW = 8;
    localparam int unsigned LENW = 4;
    localparam int unsigned NSYM = 6;
    localparam int unsigned TBLW = NSYM * ACCW;
    localparam logic [CNTW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {EMPTY, RUN, HOLD, ERR} state_t;

    state_t          state_q, state_d;
    logic [TBLW-1:0] hc_q, hc_d;
    logic [TBLW-1:0] m_q, m_d;
    logic [ACCW-1:0] acc_q, acc_d;
    logic [LENW-1:0] len_q, len_d;
    logic [2:0]      sym_q, sym_d;
    logic            sym_valid_q, sym_valid_d;
    logic            bit_ready_q, bit_ready_d;
    logic            err_q, err_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [ACCW-1:0] acc_new;
    logic [LENW-1:0] len_new;
    logic            hit;
    logic [2:0]      hit_sym;
    logic            tbl_ok;
    logic            accept;

    // A table is usable when every mask is 1..MAXLEN right-aligned ones and no code bit lies outside its mask
    function automatic logic table_valid(input logic [TBLW-1:0] hc, input logic [TBLW-1:0] m);
        logic            ok;
        logic [ACCW-1:0] mk;
        logic [ACCW-1:0] hk;
        ok = 1'b1;
        for (int unsigned k = 0; k < NSYM; k++) begin
            mk = m[k*ACCW +: ACCW];
            hk = hc[k*ACCW +: ACCW];
            if ((mk == '0) || ($unsigned($countones(mk)) > MAXLEN) ||
                ((mk & (mk + ACCW'(1))) != '0) || ((hk & ~mk) != '0)) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Candidate accumulator after shifting in the offered bit, and the lowest-index symbol it completes
    always_comb begin
        acc_new = {acc_q[ACCW-2:0], bus.bit_in};
        len_new = len_q + LENW'(1);
        hit     = 1'b0;
        hit_sym = '0;
        for (int unsigned k = 0; k < NSYM; k++) begin
            if (!hit && (LENW'($countones(m_q[k*ACCW +: ACCW])) == len_new) &&
                ((acc_new & m_q[k*ACCW +: ACCW]) == hc_q[k*ACCW +: ACCW])) begin
                hit     = 1'b1;
                hit_sym = 3'(k + 1);
            end
        end
    end

    // Next-state and next-output logic; a table load overrides everything but reset
    always_comb begin
        state_d     = state_q;
        hc_d        = hc_q;
        m_d         = m_q;
        acc_d       = acc_q;
        len_d       = len_q;
        sym_d       = sym_q;
        sym_valid_d = sym_valid_q;
        cnt_d       = cnt_q;
        tbl_ok      = table_valid(bus.hc_table, bus.m_table);
        accept      = bus.bit_valid && bit_ready_q;

        if (bus.tbl_load) begin
            hc_d        = bus.hc_table;
            m_d         = bus.m_table;
            acc_d       = '0;
            len_d       = '0;
            sym_valid_d = 1'b0;
            cnt_d       = '0;
            state_d     = tbl_ok ? RUN : ERR;
        end else begin
            case (state_q)
                RUN: begin
                    if (accept) begin
                        if (hit) begin
                            sym_d       = hit_sym;
                            sym_valid_d = 1'b1;
                            acc_d       = '0;
                            len_d       = '0;
                            state_d     = HOLD;
                        end else if (len_new == LENW'(MAXLEN)) begin
                            acc_d   = '0;
                            len_d   = '0;
                            state_d = ERR;
                        end else begin
                            acc_d = acc_new;
                            len_d = len_new;
                        end
                    end
                end
                HOLD: begin
                    if (bus.sym_ready) begin
                        sym_valid_d = 1'b0;
                        if (cnt_q != CNT_MAX) begin
                            cnt_d = cnt_q + CNTW'(1);
                        end
                        state_d = RUN;
                    end
                end
                default: ;
            endcase
        end

        bit_ready_d = (state_d == RUN);
        err_d       = (state_d == ERR);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hc_q        <= '0;
            m_q         <= '0;
            acc_q       <= '0;
            len_q       <= '0;
            sym_q       <= '0;
            sym_valid_q <= 1'b0;
            bit_ready_q <= 1'b0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            hc_q        <= hc_d;
            m_q         <= m_d;
            acc_q       <= acc_d;
            len_q       <= len_d;
            sym_q       <= sym_d;
            sym_valid_q <= sym_valid_d;
            bit_ready_q <= bit_ready_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.bit_ready = bit_ready_q;
    assign bus.sym_valid = sym_valid_q;
    assign bus.sym       = sym_q;
    assign bus.err       = err_q;
    assign bus.sym_cnt   = cnt_q;
endmodule

// File: tb/tb_huffman_decoder.sv
// Scoreboard bench for huffman_decoder: a bit-level reference model predicts handshakes,
// error and counter each cycle and queues expected symbols for a separate monitor.
module tb_huffman_decoder;
    localparam int unsigned CNTW = 7;
    localparam int CNT_SAT = 127;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;
    int   cyc;
    logic rand_mode;

    huffman_decoder_if #(.CNTW(CNTW)) bus ();

    huffman_decoder #(.MAXLEN(7), .CNTW(CNTW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    // Reference code book (symbol k at index k-1) used for directed and random streams
    int ref_code [6] = '{1, 0, 3, 4, 11, 10};
    int ref_len  [6] = '{1, 2, 3, 4, 5, 5};

    int exp_sym [$];
    int exp_cyc [$];

    function automatic void check(input string name, input int act, input int exp);
        vectors = vectors + 1;
        if (act != exp) begin
            miscompares = miscompares + 1;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    int  m_code [6];
    int  m_len  [6];
    bit  m_have;
    bit  m_error;
    bit  m_pending;
    int  m_val;
    int  m_bits;
    int  m_count;

    initial begin
        m_have = 0; m_error = 0; m_pending = 0; m_val = 0; m_bits = 0; m_count = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("bit_ready", int'(bus.bit_ready), int'(m_have && !m_error && !m_pending));
                check("err", int'(bus.err), int'(m_error));
                check("sym_valid", int'(bus.sym_valid), int'(m_pending));
                check("sym_cnt", int'(bus.sym_cnt), m_count);
            end
            if (reset) begin
                m_have = 0; m_error = 0; m_pending = 0; m_val = 0; m_bits = 0; m_count = 0;
            end else if (bus.tbl_load) begin
                logic [47:0] hcv;
                logic [47:0] mv;
                bit ok;
                hcv = bus.hc_table;
                mv  = bus.m_table;
                ok  = 1;
                for (int k = 0; k < 6; k++) begin
                    int mk;
                    int hk;
                    mk = int'(mv[k*8 +: 8]);
                    hk = int'(hcv[k*8 +: 8]);
                    m_len[k]  = $countones(mk);
                    m_code[k] = hk;
                    if (m_len[k] < 1 || m_len[k] > 7 || mk != (1 << m_len[k]) - 1 || (hk & ~mk) != 0)
                        ok = 0;
                end
                m_have = 1; m_error = !ok; m_pending = 0; m_val = 0; m_bits = 0; m_count = 0;
            end else if (m_have && !m_error && !m_pending && bus.bit_valid) begin
                int found;
                m_val  = m_val * 2 + int'(bus.bit_in);
                m_bits = m_bits + 1;
                found  = 0;
                for (int k = 0; k < 6; k++)
                    if (found == 0 && m_len[k] == m_bits && m_code[k] == m_val) found = k + 1;
                if (found != 0) begin
                    exp_sym.push_back(found);
                    exp_cyc.push_back(cyc + 1);
                    m_pending = 1; m_val = 0; m_bits = 0;
                end else if (m_bits == 7) begin
                    m_error = 1; m_val = 0; m_bits = 0;
                end
            end else if (m_pending && bus.sym_ready) begin
                m_pending = 0;
                if (m_count < CNT_SAT) m_count = m_count + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin
        bit mon_prev;
        int held;
        mon_prev = 0;
        held = 0;
        forever begin
            @(negedge clk);
            if (!reset && bus.sym_valid) begin
                if (!mon_prev) begin
                    if (exp_sym.size() == 0) begin
                        check("unexpected_sym", int'(bus.sym), 0);
                    end else begin
                        int es;
                        int ec;
                        es = exp_sym.pop_front();
                        ec = exp_cyc.pop_front();
                        check("sym", int'(bus.sym), es);
                        check("sym_latency_cycle", cyc, ec);
                        held = es;
                    end
                end else begin
                    check("sym_held", int'(bus.sym), held);
                end
            end
            mon_prev = !reset && bus.sym_valid;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus.sym_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic send_bit(input logic b);
        int n;
        n = 0;
        bus.bit_valid = 1'b1;
        bus.bit_in    = b;
        @(negedge clk);
        while (!bus.bit_ready && n < 200) begin
            tick();
            @(negedge clk);
            n = n + 1;
        end
        if (!bus.bit_ready) check("bit_accept_timeout", 0, 1);
        tick();
        bus.bit_valid = 1'b0;
    endtask

    task automatic send_sym(input int k);
        for (int i = ref_len[k-1] - 1; i >= 0; i--) send_bit(logic'((ref_code[k-1] >> i) & 1));
    endtask

    task automatic load(input logic [47:0] hc, input logic [47:0] m);
        bus.hc_table = hc;
        bus.m_table  = m;
        bus.tbl_load = 1'b1;
        tick();
        bus.tbl_load = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.bit_valid = 1'b0;
        repeat (n) tick();
    endtask

    localparam logic [47:0] REF_HC = {8'h0A, 8'h0B, 8'h04, 8'h03, 8'h00, 8'h01};
    localparam logic [47:0] REF_M  = {8'h1F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01};

    initial begin
        logic [19:0] stream;
        vectors = 0;
        miscompares = 0;
        rand_mode = 1'b0;
        reset = 1'b1;
        bus.tbl_load = 1'b0;
        bus.hc_table = '0;
        bus.m_table = '0;
        bus.bit_valid = 1'b0;
        bus.bit_in = 1'b0;
        bus.sym_ready = 1'b1;
        stream = 20'b1000_1101_0001_0110_1010;

        // Reset, then idle in EMPTY with bits offered
        repeat (3) tick();
        @(negedge clk);
        check("sym_after_reset", int'(bus.sym), 0);
        tick();
        reset = 1'b0;
        bus.bit_valid = 1'b1;
        bus.bit_in = 1'b1;
        repeat (4) tick();
        idle(1);

        // Reference table, continuous stream, consumer always ready
        load(REF_HC, REF_M);
        for (int i = 19; i >= 0; i--) send_bit(stream[i]);
        idle(4);
        check("cnt_after_stream", int'(bus.sym_cnt), 6);

        // Backpressure after first symbol; held bit must not be lost
        load(REF_HC, REF_M);
        bus.sym_ready = 1'b0;
        send_bit(stream[19]);
        bus.bit_valid = 1'b1;
        bus.bit_in = stream[18];
        repeat (6) tick();
        bus.sym_ready = 1'b1;
        for (int i = 18; i >= 0; i--) send_bit(stream[i]);
        idle(4);
        check("cnt_after_backpressure", int'(bus.sym_cnt), 6);

        // Invalid mask M3 = 05
        load(REF_HC, {8'h1F, 8'h1F, 8'h0F, 8'h05, 8'h03, 8'h01});
        bus.bit_valid = 1'b1;
        repeat (3) tick();
        idle(1);
        check("err_invalid_table", int'(bus.err), 1);

        // Overlong code: seven 1s against 5-bit codes 01..06
        load({8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}, {6{8'h1F}});
        repeat (7) send_bit(1'b1);
        idle(3);
        check("err_overlong", int'(bus.err), 1);

        // Reload mid-code: two symbols, partial code, reload, then a single 1 bit
        load(REF_HC, REF_M);
        send_sym(1);
        send_sym(2);
        send_bit(1'b0);
        send_bit(1'b1);
        load(REF_HC, REF_M);
        send_bit(1'b1);
        idle(3);
        check("cnt_after_reload", int'(bus.sym_cnt), 1);

        // Non-prefix-free table: duplicate codes resolve to lowest index
        load({8'h03, 8'h03, 8'h01, 8'h00, 8'h02, 8'h02}, {6{8'h03}});
        send_bit(1'b1); send_bit(1'b0);
        send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b1);
        idle(3);

        // Random symbols, random gaps and consumer stalls; count runs into saturation
        load(REF_HC, REF_M);
        rand_mode = 1'b1;
        for (int n = 0; n < 180; n++) begin
            int gap;
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
            send_sym(int'($urandom_range(1, 6)));
        end
        rand_mode = 1'b0;
        bus.sym_ready = 1'b1;
        idle(5);
        check("cnt_saturated", int'(bus.sym_cnt), CNT_SAT);
        check("scoreboard_empty", exp_sym.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
